// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
// Time-setting sequencer for the hour/minute/second counter chain. Turns the
// debounced mode/up/down buttons into a set-mode FSM plus one-cycle
// increment/decrement pulses (with hold-to-repeat), a seconds-clear pulse and
// a display blink control. All outputs are registered.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   tick_1hz  in   one-cycle pulse per second, synchronous to clk
//   btn_mode  in   debounced mode button (level, active-high)
//   btn_up    in   debounced up button (level, active-high)
//   btn_down  in   debounced down button (level, active-high)
//   run_en    out  1 = time chain counts; 0 = halted for setting
//   sel       out  one-hot field select {hr,min,sec}; 000 in RUN
//   inc       out  one-cycle increment pulse per field {hr,min,sec}
//   dec       out  one-cycle decrement pulse per field {hr,min,sec}
//   sec_clr   out  one-cycle pulse zeroing the seconds counter
//   blink     out  1 = selected field visible; 0 = blanked
//   state     out  RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4,
    parameter int TIMEOUT_S     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       run_en,
    output logic [2:0] sel,
    output logic [2:0] inc,
    output logic [2:0] dec,
    output logic       sec_clr,
    output logic       blink,
    output logic [1:0] state
);

    localparam int DW = $clog2(REPEAT_DELAY) + 1;
    localparam int PW = $clog2(REPEAT_PERIOD) + 1;
    localparam int TW = $clog2(TIMEOUT_S) + 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_SET_SEC = 2'd3
    } state_t;

    function automatic logic [2:0] f_sel(input state_t s);
        case (s)
            ST_SET_HR:  return 3'b100;
            ST_SET_MIN: return 3'b010;
            ST_SET_SEC: return 3'b001;
            default:    return 3'b000;
        endcase
    endfunction

    state_t          r_state;
    logic            r_mode_d, r_up_d, r_down_d;
    logic            r_live;     // low for the first edge after reset
    logic            r_armed;    // a held button has produced its first pulse
    logic [DW-1:0]   r_hold;     // cycles since first pulse, saturates at REPEAT_DELAY
    logic [PW-1:0]   r_rep;      // cycles since last repeat pulse
    logic [TW-1:0]   r_idle;     // seconds without a button edge
    logic            r_phase;    // free blink phase, overridden while editing
    logic            r_run_en, r_sec_clr, r_blink;
    logic [2:0]      r_sel, r_inc, r_dec;

    // Rises are suppressed on the first edge after reset so a button held
    // through reset release must go low before it counts.
    logic w_rise_mode, w_rise_up, w_rise_down, w_any_rise;
    assign w_rise_mode = r_live & btn_mode & ~r_mode_d;
    assign w_rise_up   = r_live & btn_up   & ~r_up_d;
    assign w_rise_down = r_live & btn_down & ~r_down_d;
    assign w_any_rise  = w_rise_mode | w_rise_up | w_rise_down;

    logic          w_in_set, w_timeout;
    logic [TW-1:0] w_idle_inc;
    assign w_in_set   = (r_state != ST_RUN);
    assign w_idle_inc = r_idle + TW'(1);
    assign w_timeout  = w_in_set & ~w_any_rise & tick_1hz & (w_idle_inc == TW'(TIMEOUT_S));

    // A single up/down rise pulses; a continuing single-button hold repeats.
    // Mode wins over up/down in the same cycle.
    logic w_single_rise, w_hold_ok, w_hold_sat, w_rep_fire;
    logic w_pulse_up, w_pulse_down;
    assign w_single_rise = w_in_set & ~w_rise_mode & (w_rise_up ^ w_rise_down);
    assign w_hold_ok     = w_in_set & ~w_rise_mode & ~w_rise_up & ~w_rise_down
                           & (btn_up ^ btn_down) & r_armed;
    assign w_hold_sat    = (r_hold == DW'(REPEAT_DELAY));
    assign w_rep_fire    = w_hold_ok & (w_hold_sat ? (r_rep + PW'(1) == PW'(REPEAT_PERIOD))
                                                   : (r_hold + DW'(1) == DW'(REPEAT_DELAY)));
    assign w_pulse_up    = (w_single_rise & w_rise_up)   | (w_rep_fire & btn_up);
    assign w_pulse_down  = (w_single_rise & w_rise_down) | (w_rep_fire & btn_down);

    state_t        w_next_state;
    logic          w_state_chg, w_armed_next, w_phase_next, w_blink_next;
    logic [DW-1:0] w_hold_next;
    logic [PW-1:0] w_rep_next;
    logic [TW-1:0] w_idle_next;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_next_state = r_state;
        if (w_rise_mode)
            w_next_state = state_t'(r_state + 2'd1);
        else if (w_timeout)
            w_next_state = ST_RUN;
        w_state_chg = (w_next_state != r_state);

        w_armed_next = 1'b0;
        w_hold_next  = '0;
        w_rep_next   = '0;
        if (!w_state_chg) begin
            if (w_single_rise) begin
                w_armed_next = 1'b1;
            end else if (w_hold_ok) begin
                w_armed_next = 1'b1;
                if (!w_hold_sat) begin
                    w_hold_next = r_hold + DW'(1);
                end else begin
                    w_hold_next = r_hold;
                    w_rep_next  = w_rep_fire ? '0 : r_rep + PW'(1);
                end
            end
        end

        // Blink restarts visible on any entry; while editing it is pinned
        // on but the phase keeps toggling underneath.
        w_phase_next = 1'b1;
        w_blink_next = 1'b1;
        if (w_in_set && !w_state_chg) begin
            w_phase_next = r_phase ^ tick_1hz;
            w_blink_next = w_pulse_up | w_pulse_down | w_hold_ok | w_phase_next;
        end

        w_idle_next = r_idle;
        if (!w_in_set || w_state_chg || w_any_rise)
            w_idle_next = '0;
        else if (tick_1hz)
            w_idle_next = w_idle_inc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_mode_d  <= 1'b0;
            r_up_d    <= 1'b0;
            r_down_d  <= 1'b0;
            r_live    <= 1'b0;
            r_armed   <= 1'b0;
            r_hold    <= '0;
            r_rep     <= '0;
            r_idle    <= '0;
            r_phase   <= 1'b1;
            r_run_en  <= 1'b1;
            r_sel     <= 3'b000;
            r_inc     <= 3'b000;
            r_dec     <= 3'b000;
            r_sec_clr <= 1'b0;
            r_blink   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            r_state   <= w_next_state;
            r_mode_d  <= btn_mode;
            r_up_d    <= btn_up;
            r_down_d  <= btn_down;
            r_live    <= 1'b1;
            r_armed   <= w_armed_next;
            r_hold    <= w_hold_next;
            r_rep     <= w_rep_next;
            r_idle    <= w_idle_next;
            r_phase   <= w_phase_next;
            r_run_en  <= (w_next_state == ST_RUN);
            r_sel     <= f_sel(w_next_state);
            // r_sel still names the field selected before this edge.
            r_inc     <= w_pulse_up   ? r_sel : 3'b000;
            r_dec     <= w_pulse_down ? r_sel : 3'b000;
            r_sec_clr <= w_rise_mode & (r_state == ST_SET_SEC);
            r_blink   <= w_blink_next;
        end
    end

    assign run_en  = r_run_en;
    assign sel     = r_sel;
    assign inc     = r_inc;
    assign dec     = r_dec;
    assign sec_clr = r_sec_clr;
    assign blink   = r_blink;
    assign state   = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
// Self-checking bench for clock_set_ctrl: hand-written table and corner-case
// sequences plus randomized button/tick traffic, all compared every cycle
// against a behavioural model kept here.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int RD = 8;
    localparam int RP = 4;
    localparam int TO = 10;
    localparam logic [13:0] RST_VEC = {2'd0, 1'b1, 3'b000, 3'b000, 3'b000, 1'b0, 1'b1};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       run_en, sec_clr, blink;
    logic [2:0] sel, inc, dec;
    logic [1:0] state;

    always #5 clk = ~clk;

    clock_set_ctrl #(.REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .TIMEOUT_S(TO)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .run_en(run_en), .sel(sel), .inc(inc), .dec(dec),
        .sec_clr(sec_clr), .blink(blink), .state(state)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    function automatic logic [13:0] dut_vec();
        return {state, run_en, sel, inc, dec, sec_clr, blink};
    endfunction

    // ---------------- behavioural reference model ----------------
    int          m_state, m_held, m_idle;
    logic [2:0]  m_prev;
    logic        m_first, m_armed, m_phase;
    logic [13:0] m_exp;

    function automatic logic [2:0] field_of(input int s);
        case (s)
            1: return 3'b100;
            2: return 3'b010;
            3: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_held = 0; m_idle = 0;
        m_prev = 3'b000; m_first = 1'b1; m_armed = 1'b0; m_phase = 1'b1;
        m_exp = RST_VEC;
    endtask

    task automatic model_step(input logic m, input logic u, input logic d, input logic t);
        logic rm, ru, rd, pu, pd, sc, bl, in_set, active;
        int   nxt;
        rm = m & ~m_prev[2] & ~m_first;
        ru = u & ~m_prev[1] & ~m_first;
        rd = d & ~m_prev[0] & ~m_first;
        m_prev = {m, u, d};
        m_first = 1'b0;
        in_set = (m_state != 0);
        nxt = m_state; sc = 1'b0; pu = 1'b0; pd = 1'b0; bl = 1'b1;
        if (rm) begin
            nxt = (m_state + 1) % 4;
            sc  = (m_state == 3);
        end else if (in_set && !ru && !rd && t && (m_idle + 1 == TO)) begin
            nxt = 0;
        end
        if (in_set && !rm) begin
            if (ru != rd) begin
                pu = ru; pd = rd; m_armed = 1'b1; m_held = 0;
            end else if (m_armed && (u != d) && !ru && !rd) begin
                m_held++;
                if (m_held >= RD && (m_held - RD) % RP == 0) begin
                    pu = u; pd = d;
                end
            end else begin
                m_armed = 1'b0;
            end
        end else begin
            m_armed = 1'b0;
        end
        active = pu | pd | m_armed;
        if (nxt != m_state) begin
            m_armed = 1'b0; m_idle = 0; m_phase = 1'b1; bl = 1'b1;
        end else if (in_set) begin
            m_idle = (ru || rd) ? 0 : m_idle + int'(t);
            if (t) m_phase = ~m_phase;
            bl = active | m_phase;
        end else begin
            m_idle = 0; m_phase = 1'b1; bl = 1'b1;
        end
        m_exp = {nxt[1:0], (nxt == 0), field_of(nxt),
                 pu ? field_of(m_state) : 3'b000,
                 pd ? field_of(m_state) : 3'b000, sc, bl};
        m_state = nxt;
    endtask

    // Called at a negedge; returns at the next negedge with outputs stable.
    task automatic step(input logic m, input logic u, input logic d, input logic t, input string name);
        btn_mode = m; btn_up = u; btn_down = d; tick_1hz = t;
        @(posedge clk);
        #1;
        model_step(m, u, d, t);
        check(name, dut_vec(), m_exp);
        @(negedge clk);
    endtask

    task automatic press_mode();
        step(1'b1, 1'b0, 1'b0, 1'b0, "mode_press");
        step(1'b0, 1'b0, 1'b0, 1'b0, "mode_rel");
    endtask

    // Asserts reset between clock edges and checks the asynchronous response.
    task automatic do_reset(input logic m, input logic u, input logic d);
        btn_mode = m; btn_up = u; btn_down = d; tick_1hz = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_vals", dut_vec(), RST_VEC);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic       m, u, d, t;
        logic [1:0] st;
        logic [2:0] sl;
        logic       run, sc;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int cnt, bad;
        int rate;
        logic m, u, d;

        // Four mode presses from RUN: state/sel/run_en/sec_clr per cycle.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 3'b100, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'b100, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 3'b010, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 3'b010, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 3'b001, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'b001, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b1, 1'b0};

        model_reset();
        @(negedge clk);
        check("reset_vals_initial", dut_vec(), RST_VEC);

        // Mode held through reset release must not advance the FSM.
        btn_mode = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, "held_mode");
        check("held_mode_state", state, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "held_mode_rel");
        step(1'b1, 1'b0, 1'b0, 1'b0, "held_mode_rise");
        check("held_mode_rise_state", state, 1);
        do_reset(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "idle");

        // Table: mode cycling.
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].m, tbl[i].u, tbl[i].d, tbl[i].t, "tbl");
            check("tbl_state", state, tbl[i].st);
            check("tbl_sel", sel, tbl[i].sl);
            check("tbl_run_en", run_en, tbl[i].run);
            check("tbl_sec_clr", sec_clr, tbl[i].sc);
        end

        // Hold up for 30 cycles in SET_MIN: pulses at 0,8,12,...,28.
        press_mode(); press_mode();
        cnt = 0; bad = 0;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, "hold_up");
            if (inc == 3'b010) cnt++;
            if (dec != 3'b000) bad++;
            check("hold_up_pos", (inc == 3'b010),
                  (k == 0 || (k >= RD && (k - RD) % RP == 0)));
        end
        check("hold_up_count", cnt, 7);
        check("hold_up_no_dec", bad, 0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, "hold_up_rel");
            if (inc != 3'b000) cnt++;
        end
        check("hold_up_rel_none", cnt, 0);
        press_mode(); press_mode();
        check("back_to_run", state, 0);

        // Mode and down rising together in SET_HR: mode wins.
        press_mode();
        step(1'b1, 1'b0, 1'b1, 1'b0, "mode_down");
        check("mode_down_state", state, 2);
        check("mode_down_pulses", {inc, dec}, 6'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "mode_down_rel");
        press_mode(); press_mode();

        // Timeout from SET_SEC after 10 ticks, no sec_clr, blink toggling.
        press_mode(); press_mode(); press_mode();
        check("to_entry_state", state, 3);
        for (int tk = 1; tk <= TO; tk++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, "to_gap");
            step(1'b0, 1'b0, 1'b0, 1'b0, "to_gap");
            step(1'b0, 1'b0, 1'b0, 1'b1, "to_tick");
            if (tk < TO) begin
                check("to_state", state, 3);
                check("to_blink", blink, (tk % 2 == 0));
            end else begin
                check("to_state_final", state, 0);
                check("to_sec_clr", sec_clr, 0);
                check("to_blink_run", blink, 1);
            end
        end

        // Up/down in RUN are ignored.
        bad = 0;
        step(1'b0, 1'b1, 1'b0, 1'b0, "run_up");   bad += int'(inc != 0) + int'(dec != 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "run_rel");
        step(1'b0, 1'b0, 1'b1, 1'b0, "run_down"); bad += int'(inc != 0) + int'(dec != 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "run_rel");
        check("run_ignored", bad, 0);
        check("run_state", state, 0);

        // Up and down rising together in SET_HR, then both held.
        press_mode();
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, "both");
            if (inc != 0 || dec != 0) cnt++;
        end
        check("both_no_pulse", cnt, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "both_rel");
        press_mode(); press_mode(); press_mode();

        // Reset mid SET_MIN with up held; held button gives nothing until re-pressed.
        press_mode(); press_mode();
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0, "pre_rst_up");
        do_reset(1'b0, 1'b1, 1'b0);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, "post_rst_up");
            if (inc != 0) cnt++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, "post_rst_mode");
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, "post_rst_hold");
            if (inc != 0) cnt++;
        end
        check("post_rst_no_inc", cnt, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, "post_rst_low");
        step(1'b0, 1'b1, 1'b0, 1'b0, "post_rst_repress");
        check("post_rst_inc_hr", inc, 3'b100);
        step(1'b0, 1'b0, 1'b0, 1'b0, "post_rst_rel");

        // Randomized traffic, alternating busy and quiet stretches.
        m = 1'b0; u = 1'b0; d = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            rate = ((i / 500) % 2 == 1) ? 200 : 12;
            if ($urandom_range(rate * 3 - 1) == 0) m = ~m;
            if ($urandom_range(rate - 1) == 0) u = ~u;
            if ($urandom_range(rate - 1) == 0) d = ~d;
            step(m, u, d, ($urandom_range(5) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
